// File: rtl/pll_phase_ctrl.sv
// pll_phase_ctrl: ECP5 EHXPLLL reset/lock sequencer and dynamic phase-step serialiser.
module pll_phase_ctrl #(
  parameter int SETUP        = 2,
  parameter int STEP_HIGH    = 4,
  parameter int STEP_GAP     = 8,
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_sel,
  input  logic       req_dir,
  input  logic [7:0] req_count,
  output logic       done,
  output logic       done_err,
  output logic       busy,
  input  logic       pll_lock,
  output logic       pll_rst,
  output logic [1:0] phasesel,
  output logic       phasedir,
  output logic       phasestep,
  output logic       locked,
  output logic       lock_fail
);
  localparam int TA   = RST_CYCLES > LOCK_TIMEOUT ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int TB   = SETUP > STEP_HIGH ? SETUP : STEP_HIGH;
  localparam int TC   = TB > STEP_GAP ? TB : STEP_GAP;
  localparam int TMAX = TA > TC ? TA : TC;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [2:0] S_RST = 3'd0, S_WAIT = 3'd1, S_IDLE = 3'd2, S_SETUP = 3'd3, S_HI = 3'd4, S_LO = 3'd5;
  logic [1:0] sync;
  logic lock_s;
  logic [2:0] state;
  logic [TW-1:0] timer;
  logic [7:0] cnt;
  assign lock_s = sync[1];
  always_ff @(posedge clk or posedge rst)
    if (rst) sync <= '0;
    else sync <= {sync[0], pll_lock};
  // Every output is a register; each transition sets the outputs for the state being entered.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= S_RST;
      timer     <= '0;
      cnt       <= '0;
      pll_rst   <= 1'b1;
      phasestep <= 1'b0;
      phasesel  <= 2'd0;
      phasedir  <= 1'b0;
      req_ready <= 1'b0;
      done      <= 1'b0;
      done_err  <= 1'b0;
      busy      <= 1'b1;
      locked    <= 1'b0;
      lock_fail <= 1'b0;
    end else begin
      done     <= 1'b0;
      done_err <= 1'b0;
      timer    <= timer + 1'b1;
      if (state == S_RST) begin
        if (timer == TW'(RST_CYCLES - 1)) begin
          state   <= S_WAIT;
          timer   <= '0;
          pll_rst <= 1'b0;
        end
      end else if (state == S_WAIT) begin
        if (lock_s) begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          locked    <= 1'b1;
        end else if (timer == TW'(LOCK_TIMEOUT - 1)) begin
          state     <= S_RST;
          timer     <= '0;
          pll_rst   <= 1'b1;
          lock_fail <= 1'b1;
        end
      end else if (!lock_s) begin
        state     <= S_RST;
        timer     <= '0;
        pll_rst   <= 1'b1;
        phasestep <= 1'b0;
        req_ready <= 1'b0;
        busy      <= 1'b1;
        locked    <= 1'b0;
        done      <= state != S_IDLE;
        done_err  <= state != S_IDLE;
      end else if (state == S_IDLE) begin
        if (req_valid && req_ready) begin
          phasesel  <= req_sel;
          phasedir  <= req_dir;
          cnt       <= req_count;
          timer     <= '0;
          req_ready <= 1'b0;
          if (req_count == 8'd0) done <= 1'b1;
          else begin
            state <= S_SETUP;
            busy  <= 1'b1;
          end
        end else req_ready <= 1'b1;
      end else if (state == S_SETUP) begin
        if (timer == TW'(SETUP - 1)) begin
          state     <= S_HI;
          timer     <= '0;
          phasestep <= 1'b1;
        end
      end else if (state == S_HI) begin
        if (timer == TW'(STEP_HIGH - 1)) begin
          state     <= S_LO;
          timer     <= '0;
          phasestep <= 1'b0;
        end
      end else if (timer == TW'(STEP_GAP - 1)) begin
        timer <= '0;
        cnt   <= cnt - 8'd1;
        if (cnt == 8'd1) begin
          state     <= S_IDLE;
          done      <= 1'b1;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end else state <= S_SETUP;
      end
    end
endmodule
